// File: rtl/ipm_distributed_sdpram_be_v2_0_if.sv
// Request/response bundle for the byte-enable simple-dual-port distributed RAM.
interface ipm_distributed_sdpram_be_v2_0_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ipm_distributed_sdpram_be_v2_0.sv
// Simple-dual-port distributed RAM with per-lane write enables, read enable
// with valid strobe, selectable read-during-write behaviour and an optional
// post-reset clear sequencer that presets every word.
module ipm_distributed_sdpram_be_v2_0 #(
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    OUT_REG      = 0,
  parameter string                 RDW_MODE     = "WRITE_FIRST",
  parameter bit                    CLEAR_ON_RST = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input logic clk,
  input logic rst,
  ipm_distributed_sdpram_be_v2_0_if.slave bus
);
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int NB         = DATA_WIDTH / BYTE_WIDTH;
  localparam bit READ_FIRST = (RDW_MODE == "READ_FIRST");

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_wr, acc_rd, collide;
  logic [DATA_WIDTH-1:0] wr_old, wr_merge, rd_word;
  logic [DATA_WIDTH-1:0] q1;
  logic                  v1;

  // Requests only count once the clear is done and reset is low.
  assign acc_wr  = bus.wr_en && !busy_q && !rst;
  assign acc_rd  = bus.rd_en && !busy_q && !rst;
  assign collide = acc_wr && (bus.wr_addr == bus.rd_addr);

  // Merge new lanes over the stored word; disabled lanes keep old data.
  assign wr_old = mem[bus.wr_addr];
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign wr_merge[k*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_be[k] ?
      bus.wr_data[k*BYTE_WIDTH +: BYTE_WIDTH] : wr_old[k*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // Write-first forwards the merged word on a same-address collision.
  assign rd_word = (!READ_FIRST && collide) ? wr_merge : mem[bus.rd_addr];

  // Clear sequencer state; busy is a registered copy of (state == CLEAR).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_ON_RST ? CLEAR : READY;
      busy_q   <= CLEAR_ON_RST;
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (&clr_addr) begin
        state  <= READY;
        busy_q <= 1'b0;
      end
    end
  end

  // Array update: sequencer preset while clearing, otherwise masked user write.
  always_ff @(posedge clk) begin
    if (state == CLEAR && !rst)
      mem[clr_addr] <= INIT_VALUE;
    else if (acc_wr)
      mem[bus.wr_addr] <= wr_merge;
  end

  // First output stage: loads only on accepted reads so data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= acc_rd;
      if (acc_rd) q1 <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] q2;
    logic                  v2;

    // Second output stage copies the first on its valid cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        q2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) q2 <= q1;
      end
    end

    assign bus.rd_data  = q2;
    assign bus.rd_valid = v2;
  end else begin : g_noreg
    assign bus.rd_data  = q1;
    assign bus.rd_valid = v1;
  end

  assign bus.busy = busy_q;
endmodule

// File: tb/tb_ipm_distributed_sdpram_be_v2_0.sv
// Directed bench: one write-first/1-cycle instance and one read-first/2-cycle
// instance share stimulus; outputs of both are checked every cycle.
module tb_ipm_distributed_sdpram_be_v2_0;
  localparam logic [31:0] A5 = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ipm_distributed_sdpram_be_v2_0_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) bus0 ();
  ipm_distributed_sdpram_be_v2_0_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) bus1 ();

  assign bus1.wr_en   = bus0.wr_en;
  assign bus1.wr_addr = bus0.wr_addr;
  assign bus1.wr_data = bus0.wr_data;
  assign bus1.wr_be   = bus0.wr_be;
  assign bus1.rd_en   = bus0.rd_en;
  assign bus1.rd_addr = bus0.rd_addr;

  ipm_distributed_sdpram_be_v2_0 #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUT_REG(0),
    .RDW_MODE("WRITE_FIRST"), .CLEAR_ON_RST(1'b1), .INIT_VALUE(A5)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  ipm_distributed_sdpram_be_v2_0 #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUT_REG(1),
    .RDW_MODE("READ_FIRST"), .CLEAR_ON_RST(1'b1), .INIT_VALUE(A5)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl [15];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic we, logic [3:0] wa, logic [31:0] wd, logic [3:0] be,
                              logic re, logic [3:0] ra, logic v0, logic [31:0] d0,
                              logic v1, logic [31:0] d1);
    vec_t r;
    r.we = we; r.wa = wa; r.wd = wd; r.be = be; r.re = re; r.ra = ra;
    r.v0 = v0; r.d0 = d0; r.v1 = v1; r.d1 = d1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra);
    bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd; bus0.wr_be = be;
    bus0.rd_en = re; bus0.rd_addr = ra;
  endtask

  // Count cycles with busy high; no read may complete meanwhile.
  task automatic wait_clear(input string name);
    int n = 0;
    while (bus0.busy && n < 40) begin
      step();
      n++;
      chk({name, "_v0"}, 32'(bus0.rd_valid), 32'd0);
      chk({name, "_v1"}, 32'(bus1.rd_valid), 32'd0);
    end
    chk({name, "_len"}, 32'(n), 32'd16);
    chk({name, "_busy1"}, 32'(bus1.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(0, 0, 32'h0,        4'h0, 1, 2, 1, A5,           0, 32'h0);
    tbl[1]  = mk(1, 3, 32'h11223344, 4'hF, 0, 0, 0, A5,           1, A5);
    tbl[2]  = mk(1, 3, 32'hAABBCCDD, 4'h5, 0, 0, 0, A5,           0, A5);
    tbl[3]  = mk(0, 0, 32'h0,        4'h0, 1, 3, 1, 32'h11BB33DD, 0, A5);
    tbl[4]  = mk(1, 5, 32'h0,        4'hF, 1, 0, 1, A5,           1, 32'h11BB33DD);
    tbl[5]  = mk(1, 5, 32'hDEADBEEF, 4'hF, 1, 5, 1, 32'hDEADBEEF, 1, A5);
    tbl[6]  = mk(0, 0, 32'h0,        4'h0, 1, 5, 1, 32'hDEADBEEF, 1, 32'h0);
    tbl[7]  = mk(0, 0, 32'h0,        4'h0, 0, 0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    tbl[8]  = mk(0, 0, 32'h0,        4'h0, 0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    tbl[9]  = mk(1, 5, 32'h01234567, 4'h8, 1, 5, 1, 32'h01ADBEEF, 0, 32'hDEADBEEF);
    tbl[10] = mk(0, 0, 32'h0,        4'h0, 1, 5, 1, 32'h01ADBEEF, 1, 32'hDEADBEEF);
    tbl[11] = mk(1, 7, 32'hCAFEF00D, 4'h0, 1, 7, 1, A5,           1, 32'h01ADBEEF);
    tbl[12] = mk(0, 0, 32'h0,        4'h0, 1, 7, 1, A5,           1, A5);
    tbl[13] = mk(0, 0, 32'h0,        4'h0, 0, 0, 0, A5,           1, A5);
    tbl[14] = mk(0, 0, 32'h0,        4'h0, 0, 0, 0, A5,           0, A5);

    // Reset state
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(); step();
    chk("rst_busy0", 32'(bus0.busy), 32'd1);
    chk("rst_busy1", 32'(bus1.busy), 32'd1);
    chk("rst_v0", 32'(bus0.rd_valid), 32'd0);
    chk("rst_v1", 32'(bus1.rd_valid), 32'd0);
    chk("rst_d0", bus0.rd_data, 32'h0);
    chk("rst_d1", bus1.rd_data, 32'h0);

    // First clear with requests pending that must be ignored
    rst = 1'b0;
    drive(1, 2, 32'hFFFFFFFF, 4'hF, 1, 2);
    wait_clear("clear1");
    drive(0, 0, 0, 0, 0, 0);

    // Table: byte enables, collisions, holds
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra);
      step();
      chk($sformatf("row%0d_v0", i), 32'(bus0.rd_valid), 32'(tbl[i].v0));
      chk($sformatf("row%0d_d0", i), bus0.rd_data, tbl[i].d0);
      chk($sformatf("row%0d_v1", i), 32'(bus1.rd_valid), 32'(tbl[i].v1));
      chk($sformatf("row%0d_d1", i), bus1.rd_data, tbl[i].d1);
    end
    drive(0, 0, 0, 0, 0, 0);

    // Throughput: fill 0..7 then back-to-back reads
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'(i), 32'h10000000 + 32'(i), 4'hF, 0, 0);
      step();
      chk($sformatf("fill%0d_v0", i), 32'(bus0.rd_valid), 32'd0);
    end
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(0, 0, 0, 0, 1, 4'(c));
      else       drive(0, 0, 0, 0, 0, 0);
      step();
      chk($sformatf("burst%0d_v0", c), 32'(bus0.rd_valid), 32'(c < 8));
      chk($sformatf("burst%0d_d0", c), bus0.rd_data,
          32'h10000000 + 32'((c < 8) ? c : 7));
      chk($sformatf("burst%0d_v1", c), 32'(bus1.rd_valid), 32'(c >= 1 && c < 9));
      chk($sformatf("burst%0d_d1", c), bus1.rd_data,
          (c == 0) ? A5 : 32'h10000000 + 32'((c < 9) ? c - 1 : 7));
    end

    // Read in flight at reset is dropped by the 2-stage instance
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("flight_v0", 32'(bus0.rd_valid), 32'd1);
    chk("flight_d0", bus0.rd_data, 32'h10000000);
    chk("flight_v1", 32'(bus1.rd_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk("flight_rst_v1", 32'(bus1.rd_valid), 32'd0);
    chk("flight_rst_d1", bus1.rd_data, 32'h0);
    chk("flight_rst_d0", bus0.rd_data, 32'h0);
    chk("flight_rst_busy", 32'(bus0.busy), 32'd1);

    // Reset in the middle of the clear restarts it from zero
    rst = 1'b0;
    drive(1, 2, 32'hFFFFFFFF, 4'hF, 1, 2);
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("mid%0d_busy", i), 32'(bus0.busy), 32'd1);
      chk($sformatf("mid%0d_v1", i), 32'(bus1.rd_valid), 32'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_clear("clear2");
    drive(0, 0, 0, 0, 0, 0);

    // Whole array reads back the preset word
    for (int c = 0; c < 17; c++) begin
      if (c < 16) drive(0, 0, 0, 0, 1, 4'(c));
      else        drive(0, 0, 0, 0, 0, 0);
      step();
      chk($sformatf("init%0d_v0", c), 32'(bus0.rd_valid), 32'(c < 16));
      chk($sformatf("init%0d_d0", c), bus0.rd_data, A5);
      chk($sformatf("init%0d_v1", c), 32'(bus1.rd_valid), 32'(c >= 1));
      chk($sformatf("init%0d_d1", c), bus1.rd_data, (c == 0) ? 32'h0 : A5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
